// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, one operation in flight,
// registered operands toward the ALU and a held result on a per-requester response channel.
module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int CTRL_W      = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp_q,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_q,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [7:0] CNT_INIT = 8'(EXEC_CYCLES - 1);

    state_t            state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [7:0]        cnt_q;
    logic [WIDTH-1:0]  alu_a_q;
    logic [WIDTH-1:0]  alu_b_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [WIDTH-1:0]  rsp_q_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;

    logic idle;
    logic grant0;
    logic grant1;
    logic owner_rsp_ready;

    // On a tie the requester that did not win last time is granted.
    assign idle            = (state_q == IDLE);
    assign grant0          = req0_valid & (~req1_valid | last_grant_q);
    assign grant1          = req1_valid & (~req0_valid | ~last_grant_q);
    assign req0_ready      = idle & grant0;
    assign req1_ready      = idle & grant1;
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    assign busy        = ~idle;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_q       = rsp_q_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_q_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        alu_a_q      <= req1_ready ? req1_a : req0_a;
                        alu_b_q      <= req1_ready ? req1_b : req0_b;
                        alu_ctrl_q   <= req1_ready ? req1_ctrl : req0_ctrl;
                        owner_q      <= req1_ready;
                        last_grant_q <= req1_ready;
                        cnt_q        <= CNT_INIT;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs stay frozen while the counter runs down to the sample point.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        rsp_q_q      <= alu_q;
                        rsp0_valid_q <= ~owner_q;
                        rsp1_valid_q <= owner_q;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a cycle-level reference model predicts grants,
// response timing and results; a monitor compares them against the DUT every cycle.
module tb_alu_share_arbiter;

    localparam int W         = 32;
    localparam int CW        = 4;
    localparam int EXEC      = 1;
    localparam int EXEC_LONG = 4;

    typedef struct packed {
        logic          owner;
        logic [W-1:0]  res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [CW-1:0] req0_ctrl, req1_ctrl;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]  rsp_q, alu_a, alu_b, alu_q;
    logic [CW-1:0] alu_control;
    logic          busy;

    logic          l_req0_valid, l_req0_ready, l_req1_valid, l_req1_ready;
    logic [W-1:0]  l_req0_a, l_req0_b, l_req1_a, l_req1_b;
    logic [CW-1:0] l_req0_ctrl, l_req1_ctrl;
    logic          l_rsp0_valid, l_rsp0_ready, l_rsp1_valid, l_rsp1_ready;
    logic [W-1:0]  l_rsp_q, l_alu_a, l_alu_b, l_alu_q;
    logic [CW-1:0] l_alu_control;
    logic          l_busy;

    int testsRun    = 0;
    int testsFailed = 0;

    exp_t          sb[$];
    int            cyc = 0;
    bit            monEn = 0;
    bit            mBusy = 0;
    bit            mLast = 1;
    bit            mOwner = 0;
    int            mAcc = 0;
    logic [W-1:0]  mA = '0;
    logic [W-1:0]  mB = '0;
    logic [CW-1:0] mC = '0;
    int            acc1Count = 0;
    bit            rsp1Seen = 0;
    bit            exp0, exp1, rspDue;
    exp_t          ent;

    always #5 clk = ~clk;

    assign alu_q   = alu_a + alu_b;
    assign l_alu_q = l_alu_a + l_alu_b;

    alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW), .EXEC_CYCLES(EXEC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_q(rsp_q), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_q(alu_q), .busy(busy)
    );

    alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW), .EXEC_CYCLES(EXEC_LONG)) dutLong (
        .clk(clk), .rst(rst),
        .req0_valid(l_req0_valid), .req0_ready(l_req0_ready), .req0_a(l_req0_a), .req0_b(l_req0_b),
        .req0_ctrl(l_req0_ctrl), .rsp0_valid(l_rsp0_valid), .rsp0_ready(l_rsp0_ready),
        .req1_valid(l_req1_valid), .req1_ready(l_req1_ready), .req1_a(l_req1_a), .req1_b(l_req1_b),
        .req1_ctrl(l_req1_ctrl), .rsp1_valid(l_rsp1_valid), .rsp1_ready(l_rsp1_ready),
        .rsp_q(l_rsp_q), .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_control(l_alu_control),
        .alu_q(l_alu_q), .busy(l_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name, input int waited);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: event not seen after %0d cycles, required within bound", name, waited);
    endtask

    task automatic modelReset();
        sb.delete();
        mBusy  = 0;
        mLast  = 1;
        mOwner = 0;
        mA     = '0;
        mB     = '0;
        mC     = '0;
    endtask

    task automatic doReset();
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        checkOutput("rst_alu_control", 32'(alu_control), 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_alu_b", alu_b, 32'd0);
        checkOutput("rst_rsp_q", rsp_q, 32'd0);
        checkOutput("rst_long_busy", 32'(l_busy), 32'd0);
        modelReset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic waitAccept(input int r);
        bit got;
        int n;
        got = 0;
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = (r == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
        end
        if (!got) timeoutFail("accept_timeout", n);
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeoutFail("idle_timeout", n);
        @(posedge clk);
        #1;
    endtask

    // Reference model: one op in flight, round-robin on ties, result due EXEC edges after acceptance.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && monEn) begin
                exp0   = !mBusy && req0_valid && (!req1_valid || mLast);
                exp1   = !mBusy && req1_valid && (!req0_valid || !mLast);
                rspDue = mBusy && (cyc - mAcc > EXEC);
                checkOutput("req0_ready", 32'(req0_ready), 32'(exp0));
                checkOutput("req1_ready", 32'(req1_ready), 32'(exp1));
                checkOutput("busy", 32'(busy), 32'(mBusy));
                checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(rspDue && !mOwner));
                checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(rspDue && mOwner));
                checkOutput("alu_a_hold", alu_a, mA);
                checkOutput("alu_b_hold", alu_b, mB);
                checkOutput("alu_control_hold", 32'(alu_control), 32'(mC));
                if (rsp1_valid) rsp1Seen = 1;
                if (rsp0_valid || rsp1_valid) begin
                    if (sb.size() == 0) begin
                        timeoutFail("rsp_without_request", 0);
                    end else begin
                        checkOutput("rsp_q", rsp_q, sb[0].res);
                        checkOutput("rsp_owner", 32'(rsp1_valid), 32'(sb[0].owner));
                    end
                end
                if (rspDue && (mOwner ? rsp1_ready : rsp0_ready)) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    mBusy = 0;
                end
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    ent.owner = !(req0_valid && req0_ready);
                    mA = ent.owner ? req1_a : req0_a;
                    mB = ent.owner ? req1_b : req0_b;
                    mC = ent.owner ? req1_ctrl : req0_ctrl;
                    ent.res = mA + mB;
                    sb.push_back(ent);
                    mBusy  = 1;
                    mAcc   = cyc;
                    mOwner = ent.owner;
                    mLast  = ent.owner;
                    if (ent.owner) acc1Count++;
                end
            end
        end
    end

    task automatic testSingleOp();
        rsp0_ready = 1;
        rsp1_ready = 1;
        req0_a = 32'h0; req0_b = 32'h1; req0_ctrl = 4'd3; req0_valid = 1;
        @(negedge clk);
        checkOutput("single_ready_cycle0", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1 req0_valid = 0;
        checkOutput("single_alu_control", 32'(alu_control), 32'd3);
        @(posedge clk);
        #1;
        checkOutput("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
        checkOutput("single_rsp_q", rsp_q, 32'h1);
        checkOutput("single_rsp1_valid", 32'(rsp1_valid), 32'd0);
        waitIdle();
    endtask

    task automatic testTie();
        int who, n, done0, done1;
        done0 = 0;
        done1 = 0;
        doReset();
        rsp0_ready = 1;
        rsp1_ready = 1;
        req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'd12; req0_valid = 1;
        req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'd13; req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            who = -1;
            n = 0;
            while (who < 0 && n < 50) begin
                @(negedge clk);
                n++;
                if (req0_valid && req0_ready) who = 0;
                else if (req1_valid && req1_ready) who = 1;
            end
            if (who < 0) timeoutFail("tie_accept_timeout", n);
            checkOutput("tie_grant_order", who, k % 2);
            @(posedge clk);
            #1;
            checkOutput("tie_alu_control", 32'(alu_control), (k % 2 == 1) ? 32'd13 : 32'd12);
            if (who == 0) begin
                done0++;
                if (done0 == 2) req0_valid = 0;
                else begin req0_a = $urandom; req0_b = $urandom; end
            end else if (who == 1) begin
                done1++;
                if (done1 == 2) req1_valid = 0;
                else begin req1_a = $urandom; req1_b = $urandom; end
            end
        end
        req0_valid = 0;
        req1_valid = 0;
        waitIdle();
    endtask

    task automatic testBackpressure();
        logic [W-1:0] held;
        int n;
        rsp0_ready = 1;
        rsp1_ready = 0;
        req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'd7; req1_valid = 1;
        held = req1_a + req1_b;
        waitAccept(1);
        req1_valid = 0;
        req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'd2; req0_valid = 1;
        n = 0;
        @(negedge clk);
        while (!rsp1_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp1_valid) timeoutFail("bp_rsp_timeout", n);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
            checkOutput("bp_rsp_q", rsp_q, held);
            checkOutput("bp_busy", 32'(busy), 32'd1);
            checkOutput("bp_req0_blocked", 32'(req0_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp1_ready = 1;
        @(negedge clk);
        checkOutput("bp_req0_before_consume", 32'(req0_ready), 32'd0);
        @(negedge clk);
        checkOutput("bp_req0_after_consume", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1 req0_valid = 0;
        waitIdle();
    endtask

    task automatic testWithdrawn();
        int accBefore;
        rsp0_ready = 0;
        rsp1_ready = 1;
        req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'd8; req0_valid = 1;
        waitAccept(0);
        req0_valid = 0;
        accBefore = acc1Count;
        rsp1Seen = 0;
        req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'd6; req1_valid = 1;
        repeat (3) @(posedge clk);
        #1 req1_valid = 0;
        rsp0_ready = 1;
        waitIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("withdraw_no_op", acc1Count, accBefore);
        checkOutput("withdraw_no_rsp1", 32'(rsp1Seen), 32'd0);
    endtask

    task automatic testResetMidOp();
        rsp0_ready = 1;
        rsp1_ready = 1;
        req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'd5; req0_valid = 1;
        waitAccept(0);
        req0_valid = 0;
        checkOutput("midrst_pre_busy", 32'(busy), 32'd1);
        req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'd9;  req0_valid = 1;
        req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'd10; req1_valid = 1;
        doReset();
        @(negedge clk);
        checkOutput("midrst_tie_ready0", 32'(req0_ready), 32'd1);
        checkOutput("midrst_tie_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1 req0_valid = 0;
        waitAccept(1);
        req1_valid = 0;
        waitIdle();
    endtask

    task automatic testLatency();
        int n;
        bit got;
        l_rsp0_ready = 1;
        l_req0_a = 32'd5; l_req0_b = 32'd6; l_req0_ctrl = 4'd1; l_req0_valid = 1;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = l_req0_ready;
        end
        if (!got) timeoutFail("lat_accept_timeout", n);
        @(posedge clk);
        #1 l_req0_valid = 0;
        for (int k = 1; k <= EXEC_LONG + 1; k++) begin
            @(negedge clk);
            checkOutput("lat_rsp0_valid", 32'(l_rsp0_valid), 32'(k == EXEC_LONG + 1));
            checkOutput("lat_alu_a", l_alu_a, 32'd5);
            checkOutput("lat_alu_b", l_alu_b, 32'd6);
            checkOutput("lat_busy", 32'(l_busy), 32'd1);
        end
        checkOutput("lat_rsp_q", l_rsp_q, 32'd11);
        checkOutput("lat_alu_control", 32'(l_alu_control), 32'd1);
        checkOutput("lat_rsp1_valid", 32'(l_rsp1_valid), 32'd0);
        checkOutput("lat_req1_ready", 32'(l_req1_ready), 32'd0);
        @(negedge clk);
        checkOutput("lat_busy_after", 32'(l_busy), 32'd0);
    endtask

    task automatic applyStimulus(input int cycles);
        bit acc0, acc1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (req0_valid && !acc0) begin
                if ($urandom_range(9) == 0) req0_valid = 0;
            end else if ($urandom_range(9) < 4) begin
                req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'($urandom);
            end else begin
                req0_valid = 0;
            end
            if (req1_valid && !acc1) begin
                if ($urandom_range(9) == 0) req1_valid = 0;
            end else if ($urandom_range(9) < 4) begin
                req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'($urandom);
            end else begin
                req1_valid = 0;
            end
            rsp0_ready = ($urandom_range(9) < 6);
            rsp1_ready = ($urandom_range(9) < 6);
        end
        req0_valid = 0;
        req1_valid = 0;
        rsp0_ready = 1;
        rsp1_ready = 1;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_ctrl = '0; rsp0_ready = 1;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_ctrl = '0; rsp1_ready = 1;
        l_req0_valid = 0; l_req0_a = '0; l_req0_b = '0; l_req0_ctrl = '0; l_rsp0_ready = 1;
        l_req1_valid = 0; l_req1_a = '0; l_req1_b = '0; l_req1_ctrl = '0; l_rsp1_ready = 1;
        doReset();
        monEn = 1;
        testSingleOp();
        testTie();
        testBackpressure();
        testWithdrawn();
        testResetMidOp();
        testLatency();
        applyStimulus(400);
        waitIdle();
        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
